// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline-boundary register.
package pipe_pkg;

   localparam int CTRL_W_DEF = 16;
   localparam int DATA_W_DEF = 160;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with increment enable and asynchronous active-high reset.
module pipe_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: valid/ready handshake, flush, bubble-zeroed control, stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid build with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   state_t state;
   logic   in_fire;
   logic   out_fire;

   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              in_ready_q;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   assign in_ready = in_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_ctrl   <= '0;
         out_data   <= '0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_ctrl   <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state    <= ST_BUSY;
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the new entry so in_ready can drop a cycle late.
                  state      <= ST_FULL;
                  in_ready_q <= 1'b0;
                  skid_ctrl  <= in_ctrl;
                  skid_data  <= in_data;
               end else if (out_fire) begin
                  state    <= ST_EMPTY;
                  out_ctrl <= '0;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state      <= ST_BUSY;
                  in_ready_q <= 1'b1;
                  out_ctrl   <= skid_ctrl;
                  out_data   <= skid_data;
               end
            end
            default: begin
               state      <= ST_EMPTY;
               in_ready_q <= 1'b1;
               out_ctrl   <= '0;
            end
         endcase
      end
   end
`else
   // Without a skid slot, room exists only if the held entry leaves this same cycle.
   assign in_ready = out_ready | ~out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_EMPTY;
         out_ctrl <= '0;
         out_data <= '0;
      end else if (flush) begin
         state    <= ST_EMPTY;
         out_ctrl <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state    <= ST_BUSY;
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end
            end
            ST_BUSY: begin
               if (in_fire) begin
                  out_ctrl <= in_ctrl;
                  out_data <= in_data;
               end else if (out_fire) begin
                  state    <= ST_EMPTY;
                  out_ctrl <= '0;
               end
            end
            default: begin
               state    <= ST_EMPTY;
               out_ctrl <= '0;
            end
         endcase
      end
   end
`endif

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus hand-written stall/flush/reset/saturation sequences.
module tb_pipe_stage_reg;

   localparam int CW = 16;
   localparam int DW = 160;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_ctrl = '0;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [NW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic [CW+DW-1:0] exp_q[$];

   typedef struct {
      logic          iv;
      logic [CW-1:0] ic;
      logic [DW-1:0] id;
      logic          ordy;
      logic          eir;
      logic          ev;
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      logic [NW-1:0] es;
   } vec_t;

   vec_t tbl[10];

   pipe_stage_reg #(
      .CTRL_W (CW),
      .DATA_W (DW),
      .CNT_W  (NW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic ordy, input logic fl);
      in_valid  = iv;
      in_ctrl   = ic;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
   endtask

   // Scoreboard: entries leave in acceptance order; flush and reset drop everything held.
   always @(negedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_extra: got %0h expected no entry", {out_ctrl, out_data});
            end else begin
               chk("sb_order", 192'({out_ctrl, out_data}), 192'(exp_q.pop_front()));
            end
         end
         if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      end
   end

   initial begin
      for (int k = 0; k < 10; k++) begin
         tbl[k].iv   = (k < 8);
         tbl[k].ic   = (k < 8) ? CW'(k) : '0;
         tbl[k].id   = (k < 8) ? DW'(k * 3) : '0;
         tbl[k].ordy = 1'b1;
         tbl[k].eir  = 1'b1;
         tbl[k].ev   = (k < 8);
         tbl[k].ec   = (k < 8) ? CW'(k) : '0;
         tbl[k].ed   = (k < 8) ? DW'(k * 3) : DW'(21);
         tbl[k].es   = '0;
      end

      // Asynchronous reset, checked without any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_valid", 192'(out_valid), 192'(0));
      chk("rst_ctrl",  192'(out_ctrl),  192'(0));
      chk("rst_data",  192'(out_data),  192'(0));
      chk("rst_stall", 192'(stall_cnt), 192'(0));
      chk("rst_ready", 192'(in_ready),  192'(1));
      tick();
      tick();
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         drive(tbl[k].iv, tbl[k].ic, tbl[k].id, tbl[k].ordy, 1'b0);
         #1;
         chk("tbl_in_ready", 192'(in_ready), 192'(tbl[k].eir));
         tick();
         chk("tbl_valid", 192'(out_valid), 192'(tbl[k].ev));
         chk("tbl_ctrl",  192'(out_ctrl),  192'(tbl[k].ec));
         chk("tbl_data",  192'(out_data),  192'(tbl[k].ed));
         chk("tbl_stall", 192'(stall_cnt), 192'(tbl[k].es));
      end

`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 16'h00A1, 160'hA1A1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 16'h00B2, 160'hB2B2, 1'b0, 1'b0);
      tick();
      chk("bp_ready_low", 192'(in_ready),  192'(0));
      chk("bp_stall",     192'(stall_cnt), 192'(1));
      chk("bp_hold_ctrl", 192'(out_ctrl),  192'(16'h00A1));
      drive(1'b1, 16'h00C3, 160'hC3C3, 1'b1, 1'b0);
      #1;
      chk("bp_ready_low2", 192'(in_ready), 192'(0));
      tick();
      chk("bp_ready_back", 192'(in_ready), 192'(1));
      chk("bp_ctrl_b",     192'(out_ctrl), 192'(16'h00B2));
      tick();
      chk("bp_ctrl_c",     192'(out_ctrl), 192'(16'h00C3));
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      chk("bp_drained",    192'(out_valid), 192'(0));
`else
      drive(1'b1, 16'h00A1, 160'hA1A1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 16'h00B2, 160'hB2B2, 1'b0, 1'b0);
      #1;
      chk("ns_ready_low", 192'(in_ready), 192'(0));
      tick();
      chk("bp_stall",     192'(stall_cnt), 192'(1));
      chk("bp_hold_ctrl", 192'(out_ctrl),  192'(16'h00A1));
      drive(1'b1, 16'h00B2, 160'hB2B2, 1'b1, 1'b0);
      #1;
      chk("ns_ready_high", 192'(in_ready), 192'(1));
      tick();
      chk("bp_ctrl_b",     192'(out_ctrl), 192'(16'h00B2));
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      chk("bp_drained",    192'(out_valid), 192'(0));
`endif

      // Flush with a new input offered in the same cycle.
      drive(1'b1, 16'h0F0A, 160'hDA7A_000A, 1'b0, 1'b0);
      tick();
`ifdef PIPE_STAGE_SKID_EN
      drive(1'b1, 16'h0F0B, 160'hDA7A_000B, 1'b0, 1'b0);
      tick();
      chk("fl_full", 192'(in_ready), 192'(0));
`endif
      drive(1'b1, 16'h0F0C, 160'hDA7A_000C, 1'b1, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      chk("fl_valid", 192'(out_valid), 192'(0));
      chk("fl_ctrl",  192'(out_ctrl),  192'(0));
      chk("fl_data",  192'(out_data),  192'(160'hDA7A_000A));
`ifdef PIPE_STAGE_SKID_EN
      chk("fl_stall", 192'(stall_cnt), 192'(2));
`else
      chk("fl_stall", 192'(stall_cnt), 192'(1));
`endif
      chk("fl_ready", 192'(in_ready), 192'(1));
      tick();
      chk("fl_no_emit", 192'(out_valid), 192'(0));

      // Reset asserted between edges while an all-ones control entry is held.
      drive(1'b1, 16'hFFFF, 160'h1234_5678, 1'b0, 1'b0);
      tick();
      chk("mr_ctrl", 192'(out_ctrl), 192'(16'hFFFF));
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
`ifdef PIPE_STAGE_SKID_EN
      chk("mr_stall_pre", 192'(stall_cnt), 192'(3));
`else
      chk("mr_stall_pre", 192'(stall_cnt), 192'(2));
`endif
      #1 rst = 1'b1;
      #1;
      chk("mr_valid", 192'(out_valid), 192'(0));
      chk("mr_ctrl0", 192'(out_ctrl),  192'(0));
      chk("mr_data0", 192'(out_data),  192'(0));
      chk("mr_stall", 192'(stall_cnt), 192'(0));
      tick();
      rst = 1'b0;

      // Saturation of the 4-bit stall counter on a held entry.
      drive(1'b1, 16'h5A5A, 160'hFEED_BEEF, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("sat_stall", 192'(stall_cnt), 192'((k > 15) ? 15 : k));
         chk("sat_valid", 192'(out_valid), 192'(1));
         chk("sat_ctrl",  192'(out_ctrl),  192'(16'h5A5A));
         chk("sat_data",  192'(out_data),  192'(160'hFEED_BEEF));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      chk("sat_drained", 192'(out_valid), 192'(0));
      chk("sat_hold",    192'(stall_cnt), 192'(15));
      tick();
      chk("sb_drain", 192'(exp_q.size()), 192'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-boundary register for the pipelined core, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. Carries a control bundle and a data bundle across a stage boundary with a valid/ready handshake, supporting stall (back-pressure) and flush (bubble insertion). Control fields are zeroed whenever the stage holds a bubble, so RegWrite/MemWrite-style bits are never spuriously active downstream. Includes a saturating stall-cycle counter for performance debug.

## Interface
- CTRL_W, 16, width of control bundle (zeroed on bubble)
- DATA_W, 160, width of data bundle (operands, PC, immediates, register indices)
- CNT_W, 16, width of stall counter

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous; discards all held entries and any input accepted this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  registered control; 0 when out_valid=0
- out_data  out  DATA_W  registered data; holds last value when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY (no entry), BUSY (main register valid), FULL (main + skid valid; skid build only).
- EMPTY: in_fire -> BUSY, main <= input.
- BUSY: in_fire & out_fire -> BUSY, main <= input; in_fire & !out_fire -> FULL, skid <= input; !in_fire & out_fire -> EMPTY, out_ctrl <= 0; else hold.
- FULL: in_ready=0; out_fire -> BUSY, main <= skid; else hold.
- flush has priority over every transition: next state EMPTY, out_valid <= 0, out_ctrl <= 0, skid discarded, in_fire in same cycle discarded; out_data unchanged.
- Held entry never changes while out_valid=1 and out_ready=0.
- stall_cnt increments when out_valid & !out_ready, holds at 2^CNT_W-1; cleared only by rst (not flush).
- Reset (async): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid contents 0, in_ready=1 (skid build) / combinational per below.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N; one cycle.
- Throughput: one entry per cycle while out_ready=1.
- Skid build: in_ready is a register output (= state != FULL), no combinational path out_ready -> in_ready; full throughput sustained across a single-cycle out_ready drop.
- rst asserted mid-operation: outputs go to reset values immediately, independent of clk; in-flight entries lost.
- flush and rst both asserted: rst dominates (same resulting state).

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry storage (main + skid), FULL state exists, in_ready registered as above.
- Not defined: single register only, no FULL state; in_ready = out_ready | !out_valid (combinational); in_fire & !out_fire from BUSY impossible. All other behaviour (flush, bubble zeroing, stall_cnt) identical.

## Structure
- Package pipe_pkg: state enum (ST_EMPTY, ST_BUSY, ST_FULL), default widths CTRL_W_DEF=16, DATA_W_DEF=160, CNT_W_DEF=16.
- One sub-module: pipe_sat_cnt (parametrised CNT_W saturating counter with inc enable and async reset) for stall_cnt.

## Test plan
- Reset: assert rst mid-stream with out_valid=1, out_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 without a clock edge.
- Streaming: 8 entries ctrl=i, data=i*3, out_ready=1 -> outputs in order, one per cycle, one-cycle latency, in_ready stays 1.
- Back-pressure (skid build): out_ready low for 1 cycle during a stream -> in_ready low the following cycle only, no entry lost or duplicated, stall_cnt=1.
- Flush: stage FULL with entries A,B, flush=1 with in_valid=1 entry C -> next cycle out_valid=0, out_ctrl=0, A,B,C never emitted, stall_cnt unchanged.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; held entry unchanged throughout.
- Non-skid build: out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, new entry accepted.
